// File: rtl/pcm_stream_packer.sv
// Multi-channel PCM sample packer: truncates samples into a byte FIFO served to an SPI slave.
// Optional per-sample tag byte enabled by defining PCM_STREAM_PACKER_SAMPLE_TAG_EN.
module pcm_stream_packer #(
  parameter int          SAMPLE_WIDTH     = 24,
  parameter int          BYTES_PER_SAMPLE = 2,
  parameter int          NUM_CHANNELS     = 2,
  parameter int          FIFO_DEPTH       = 4096,
  parameter int          LSB_FIRST        = 1,
  parameter logic [7:0]  FILL_BYTE        = 8'h00,
  parameter int          CNT_WIDTH        = 16,
  localparam int         CH_W             = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
  localparam int         LVL_W            = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    pcm_valid,
  input  logic [SAMPLE_WIDTH-1:0] pcm_data,
  input  logic [CH_W-1:0]         pcm_channel,
  input  logic                    spi_busy,
  output logic [7:0]              spi_data_out,
  output logic                    spi_data_valid,
  output logic [LVL_W-1:0]        fifo_level,
  output logic                    fifo_empty,
  output logic                    fifo_full,
  output logic [CNT_WIDTH-1:0]    overflow_count,
  output logic [CNT_WIDTH-1:0]    underflow_count
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int KEEP_W = BYTES_PER_SAMPLE * 8;
`ifdef PCM_STREAM_PACKER_SAMPLE_TAG_EN
  localparam int NBYTES = BYTES_PER_SAMPLE + 1;
`else
  localparam int NBYTES = BYTES_PER_SAMPLE;
`endif
  localparam int IDX_W = 3;
  localparam logic [LVL_W-1:0] MAX_ACCEPT_LEVEL = LVL_W'(FIFO_DEPTH - NBYTES);

  typedef enum logic {IDLE, WRITE} state_t;

  state_t                r_state;
  logic [IDX_W-1:0]      r_idx;
  logic [KEEP_W-1:0]     r_shift;
  logic [7:0]            r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wrPtr;
  logic [PTR_W-1:0]      r_rdPtr;
  logic [LVL_W-1:0]      r_level;
  logic [7:0]            r_rdData;
  logic                  r_rdPend;
  logic                  r_fillPend;
  logic [7:0]            r_dataOut;
  logic                  r_dataValid;
  logic [2:0]            r_busySync;
  logic [CNT_WIDTH-1:0]  r_ovfCount;
  logic [CNT_WIDTH-1:0]  r_udfCount;

  logic                  w_chanOk;
  logic                  w_accept;
  logic                  w_drop;
  logic                  w_wrEn;
  logic                  w_dataCycle;
  logic [7:0]            w_dataByte;
  logic [7:0]            w_wrByte;
  logic                  w_empty;
  logic                  w_busyRise;
  logic                  w_rdEn;
  logic                  w_underflow;

  if (SAMPLE_WIDTH > KEEP_W) begin : g_discard
    logic w_unusedLowBits;
    assign w_unusedLowBits = ^pcm_data[SAMPLE_WIDTH-KEEP_W-1:0];
  end

  assign w_chanOk    = ({1'b0, pcm_channel} < (CH_W+1)'(NUM_CHANNELS));
  assign w_accept    = pcm_valid && (r_state == IDLE) && w_chanOk && (r_level <= MAX_ACCEPT_LEVEL);
  assign w_drop      = pcm_valid && !w_accept;
  assign w_wrEn      = (r_state == WRITE);
  assign w_dataByte  = (LSB_FIRST != 0) ? r_shift[7:0] : r_shift[KEEP_W-1 -: 8];
  assign w_empty     = (r_level == '0);
  assign w_busyRise  = r_busySync[1] & ~r_busySync[2];
  assign w_rdEn      = w_busyRise & ~w_empty;
  assign w_underflow = w_busyRise & w_empty;

`ifdef PCM_STREAM_PACKER_SAMPLE_TAG_EN
  logic [3:0] r_seq;
  logic [7:0] r_tag;

  // The tag is captured at acceptance so it carries this sample's sequence number.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seq <= '0;
      r_tag <= '0;
    end else if (w_accept) begin
      r_seq <= r_seq + 4'd1;
      r_tag <= {1'b1, r_seq, 3'(pcm_channel)};
    end
  end

  assign w_dataCycle = (r_idx != '0);
  assign w_wrByte    = w_dataCycle ? w_dataByte : r_tag;
`else
  assign w_dataCycle = 1'b1;
  assign w_wrByte    = w_dataByte;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_shift <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state <= WRITE;
            r_idx   <= '0;
            r_shift <= pcm_data[SAMPLE_WIDTH-1 -: KEEP_W];
          end
        end
        WRITE: begin
          if (w_dataCycle) begin
            r_shift <= (LSB_FIRST != 0) ? (r_shift >> 8) : (r_shift << 8);
          end
          r_idx <= r_idx + IDX_W'(1);
          if (r_idx == IDX_W'(NBYTES - 1)) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Storage is left unreset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (w_wrEn) begin
      r_mem[r_wrPtr] <= w_wrByte;
    end
    if (w_rdEn) begin
      r_rdData <= r_mem[r_rdPtr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_level <= '0;
    end else begin
      if (w_wrEn) r_wrPtr <= r_wrPtr + PTR_W'(1);
      if (w_rdEn) r_rdPtr <= r_rdPtr + PTR_W'(1);
      case ({w_wrEn, w_rdEn})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Pop and fill share one pipeline stage so both paths answer two cycles after the rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busySync  <= '0;
      r_rdPend    <= 1'b0;
      r_fillPend  <= 1'b0;
      r_dataOut   <= '0;
      r_dataValid <= 1'b0;
    end else begin
      r_busySync  <= {r_busySync[1:0], spi_busy};
      r_rdPend    <= w_rdEn;
      r_fillPend  <= w_underflow;
      r_dataValid <= r_rdPend | r_fillPend;
      if (r_rdPend) begin
        r_dataOut <= r_rdData;
      end else if (r_fillPend) begin
        r_dataOut <= FILL_BYTE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovfCount <= '0;
      r_udfCount <= '0;
    end else begin
      if (w_drop && (r_ovfCount != '1)) r_ovfCount <= r_ovfCount + CNT_WIDTH'(1);
      if (w_underflow && (r_udfCount != '1)) r_udfCount <= r_udfCount + CNT_WIDTH'(1);
    end
  end

  assign spi_data_out    = r_dataOut;
  assign spi_data_valid  = r_dataValid;
  assign fifo_level      = r_level;
  assign fifo_empty      = w_empty;
  assign fifo_full       = (r_level == LVL_W'(FIFO_DEPTH));
  assign overflow_count  = r_ovfCount;
  assign underflow_count = r_udfCount;

endmodule

// File: tb/tb_pcm_stream_packer.sv
// Scoreboard bench for pcm_stream_packer: queue-based reference model, decoupled output monitor.
// Honours PCM_STREAM_PACKER_SAMPLE_TAG_EN when defined.
module tb_pcm_stream_packer;

  localparam int SW    = 24;
  localparam int BPS   = 2;
  localparam int NCH   = 3;
  localparam int DEPTH = 16;
  localparam int LSBF  = 1;
  localparam int CW    = 4;
  localparam logic [7:0] FILL = 8'hE7;
  localparam int CHW   = 2;
  localparam int LVLW  = 5;
`ifdef PCM_STREAM_PACKER_SAMPLE_TAG_EN
  localparam int NB = BPS + 1;
`else
  localparam int NB = BPS;
`endif

  logic            clk;
  logic            rst_n;
  logic            pcm_valid;
  logic [SW-1:0]   pcm_data;
  logic [CHW-1:0]  pcm_channel;
  logic            spi_busy;
  logic [7:0]      spi_data_out;
  logic            spi_data_valid;
  logic [LVLW-1:0] fifo_level;
  logic            fifo_empty;
  logic            fifo_full;
  logic [CW-1:0]   overflow_count;
  logic [CW-1:0]   underflow_count;

  pcm_stream_packer #(
    .SAMPLE_WIDTH(SW), .BYTES_PER_SAMPLE(BPS), .NUM_CHANNELS(NCH), .FIFO_DEPTH(DEPTH),
    .LSB_FIRST(LSBF), .FILL_BYTE(FILL), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pcm_valid(pcm_valid), .pcm_data(pcm_data),
    .pcm_channel(pcm_channel), .spi_busy(spi_busy), .spi_data_out(spi_data_out),
    .spi_data_valid(spi_data_valid), .fifo_level(fifo_level), .fifo_empty(fifo_empty),
    .fifo_full(fifo_full), .overflow_count(overflow_count), .underflow_count(underflow_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    int         due;
  } expT;

  logic [7:0] fifoQ[$];
  logic [7:0] pendQ[$];
  logic [7:0] servedQ[$];
  expT        expQ[$];
  int         mOvf, mUdf, mSeq, cycleNum;
  logic [2:0] hist;
  int         checks, errors;
  logic       mRise, mAccept;
  int         mLvl;
  logic [7:0] mByte;
  expT        monE;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h at cycle %0d", name, actual, expected, cycleNum);
    end
  endtask

  function automatic int satInc(input int v);
    return (v == (1 << CW) - 1) ? v : v + 1;
  endfunction

  // Spec rule: keep the top BPS bytes, tag first when enabled, then in LSB_FIRST order.
  task automatic queueSample(input logic [SW-1:0] d, input int ch);
    logic [31:0] k;
    k = 32'(d) >> (SW - 8 * BPS);
`ifdef PCM_STREAM_PACKER_SAMPLE_TAG_EN
    pendQ.push_back(8'(8'h80 | (mSeq << 3) | ch));
    mSeq = (mSeq + 1) % 16;
`endif
    for (int j = 0; j < BPS; j++) begin
      if (LSBF != 0) pendQ.push_back(8'(k >> (8 * j)));
      else           pendQ.push_back(8'(k >> (8 * (BPS - 1 - j))));
    end
  endtask

  always @(posedge clk) begin
    if (rst_n) begin
      mLvl  = fifoQ.size();
      mRise = hist[1] & ~hist[2];
      if (mRise) begin
        if (mLvl > 0) begin
          mByte = fifoQ.pop_front();
        end else begin
          mByte = FILL;
          mUdf  = satInc(mUdf);
        end
        expQ.push_back('{mByte, cycleNum + 2});
      end
      mAccept = 1'b0;
      if (pcm_valid) begin
        if (pendQ.size() == 0 && int'(pcm_channel) < NCH && DEPTH - mLvl >= NB) mAccept = 1'b1;
        else mOvf = satInc(mOvf);
      end
      if (pendQ.size() > 0) fifoQ.push_back(pendQ.pop_front());
      if (mAccept) queueSample(pcm_data, int'(pcm_channel));
      hist = {hist[1:0], spi_busy};
    end
    cycleNum++;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (spi_data_valid) begin
        servedQ.push_back(spi_data_out);
        if (expQ.size() == 0) begin
          checkOutput("spiUnexpected", 1, 0);
        end else begin
          monE = expQ.pop_front();
          checkOutput("spiData", spi_data_out, monE.data);
          checkOutput("spiLatency", cycleNum, monE.due);
        end
      end else if (expQ.size() > 0 && expQ[0].due <= cycleNum) begin
        monE = expQ.pop_front();
        checkOutput("spiMissing", 0, 1);
      end
      checkOutput("fifoLevel", fifo_level, fifoQ.size());
      checkOutput("fifoEmpty", fifo_empty, fifoQ.size() == 0);
      checkOutput("fifoFull", fifo_full, fifoQ.size() == DEPTH);
      checkOutput("overflowCount", overflow_count, mOvf);
      checkOutput("underflowCount", underflow_count, mUdf);
    end
  end

  task automatic doReset();
    pcm_valid = 1'b0;
    spi_busy  = 1'b0;
    rst_n     = 1'b0;
    #1;
    fifoQ.delete(); pendQ.delete(); expQ.delete(); servedQ.delete();
    mOvf = 0; mUdf = 0; mSeq = 0; hist = '0;
    checkOutput("rstLevel", fifo_level, 0);
    checkOutput("rstEmpty", fifo_empty, 1);
    checkOutput("rstFull", fifo_full, 0);
    checkOutput("rstData", spi_data_out, 0);
    checkOutput("rstValid", spi_data_valid, 0);
    checkOutput("rstOvf", overflow_count, 0);
    checkOutput("rstUdf", underflow_count, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic applyStimulus(input logic [SW-1:0] d, input int ch);
    pcm_valid   = 1'b1;
    pcm_data    = d;
    pcm_channel = CHW'(ch);
    @(negedge clk);
    pcm_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic busyPulse();
    spi_busy = 1'b1;
    idle(2);
    spi_busy = 1'b0;
    idle(2);
  endtask

  int   nReads;
  logic done;
  logic [7:0] expFirst[$];

  initial begin
    checks = 0; errors = 0; cycleNum = 0;
    pcm_data = '0; pcm_channel = '0; pcm_valid = 1'b0; spi_busy = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    #2;
    doReset();

    // Basic sample, then serve it and one fill byte.
    applyStimulus(24'hABCDEF, 0);
    checkOutput("lvlStep0", fifo_level, 0);
    idle(1);
    checkOutput("lvlStep1", fifo_level, 1);
    idle(1);
    checkOutput("lvlStep2", fifo_level, 2);
    idle(NB);
    checkOutput("lvlAfterSample", fifo_level, NB);
    repeat (NB) busyPulse();
    idle(4);
    checkOutput("udfBeforeEmptyRead", underflow_count, 0);
    busyPulse();
    idle(4);
    checkOutput("udfAfterEmptyRead", underflow_count, 1);
`ifdef PCM_STREAM_PACKER_SAMPLE_TAG_EN
    expFirst = '{8'h80, 8'hCD, 8'hAB, FILL};
`else
    expFirst = '{8'hCD, 8'hAB, FILL};
`endif
    checkOutput("servedCount", servedQ.size(), expFirst.size());
    if (servedQ.size() == expFirst.size())
      foreach (expFirst[i]) checkOutput("servedByte", servedQ[i], expFirst[i]);

    // Back-to-back strobes: the second lands in WRITE and is dropped.
    #2;
    doReset();
    pcm_valid = 1'b1; pcm_data = 24'h112233; pcm_channel = 2'd1;
    @(negedge clk);
    pcm_data = 24'h445566;
    @(negedge clk);
    pcm_valid = 1'b0;
    idle(NB + 2);
    checkOutput("b2bOvf", overflow_count, 1);
    checkOutput("b2bLevel", fifo_level, NB);

    // Fill until no room, then drop with a registered-level check during a read.
    #2;
    doReset();
    for (int i = 0; i < 20; i++) begin
      if (fifoQ.size() + pendQ.size() + NB > DEPTH) break;
      applyStimulus(SW'($urandom), i % NCH);
      idle(NB);
    end
    checkOutput("fillLevel", fifo_level, DEPTH - (DEPTH % NB));
    checkOutput("fillFull", fifo_full, (DEPTH % NB) == 0);
    nReads = (DEPTH - (DEPTH % NB)) - (DEPTH - NB + 1);
    repeat (nReads) busyPulse();
    idle(4);
    checkOutput("nearFullLevel", fifo_level, DEPTH - NB + 1);
    applyStimulus(24'h0F0F0F, 0);
    idle(2);
    checkOutput("nearFullOvf", overflow_count, 1);
    checkOutput("nearFullKeep", fifo_level, DEPTH - NB + 1);
    spi_busy = 1'b1;
    idle(2);
    pcm_valid = 1'b1; pcm_data = 24'h777777; pcm_channel = 2'd0;
    @(negedge clk);
    pcm_valid = 1'b0; spi_busy = 1'b0;
    idle(6);
    checkOutput("riseDropOvf", overflow_count, 2);
    checkOutput("riseDropLevel", fifo_level, DEPTH - NB);

    // Reset during WRITE, then a clean sample from pointer 0.
    #2;
    doReset();
    applyStimulus(24'hFEDCBA, 1);
    @(posedge clk);
    #2;
    doReset();
    applyStimulus(24'h123456, 2);
    idle(NB + 1);
    checkOutput("postRstLevel", fifo_level, NB);
    repeat (NB) busyPulse();
    idle(4);
    checkOutput("postRstServed", servedQ.size(), NB);
`ifdef PCM_STREAM_PACKER_SAMPLE_TAG_EN
    if (servedQ.size() == NB) checkOutput("postRstTag", servedQ[0], 8'h82);
`else
    if (servedQ.size() == NB) checkOutput("postRstByte0", servedQ[0], 8'h34);
`endif

`ifdef PCM_STREAM_PACKER_SAMPLE_TAG_EN
    // Tags across 17 samples so the sequence wraps.
    #2;
    doReset();
    for (int i = 0; i < 17; i++) begin
      applyStimulus(SW'($urandom), (i % 2 == 0) ? 1 : 0);
      idle(NB);
      repeat (NB) busyPulse();
    end
    idle(6);
    checkOutput("tagServed", servedQ.size(), 17 * NB);
    if (servedQ.size() == 17 * NB) begin
      checkOutput("tag0", servedQ[0], 8'h81);
      checkOutput("tag1", servedQ[NB], 8'h88);
      checkOutput("tag2", servedQ[2 * NB], 8'h91);
      checkOutput("tagWrap", servedQ[16 * NB], 8'h81);
    end
`endif

    // Randomized traffic against the model; counters saturate at CW bits.
    #2;
    doReset();
    for (int i = 0; i < 3000; i++) begin
      pcm_valid   = ($urandom_range(0, 2) == 0);
      pcm_data    = SW'($urandom);
      pcm_channel = CHW'($urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) spi_busy = ~spi_busy;
      @(negedge clk);
    end
    pcm_valid = 1'b0;
    spi_busy  = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      if (fifoQ.size() == 0 && pendQ.size() == 0 && expQ.size() == 0) done = 1'b1;
      else if (fifoQ.size() > 0 || pendQ.size() > 0) busyPulse();
      else idle(1);
    end
    checkOutput("drainDone", done, 1);
    checkOutput("drainExpEmpty", expQ.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
